// File: rtl/btn_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_counter_pkg
// Description : Shared defaults and the count-operation type for the
//               debounced up/down/clear button counter.
//               Contents:
//                 DEF_WIDTH                    - default counter/LED width
//                 DEF_DEBOUNCE_COUNT_THRESHOLD - default stable-cycle count
//                 DEF_WRAP                     - default overflow behaviour
//                 count_op_e                   - decoded count operation
//                 decode_op()                  - press pulses -> operation
// Revision    : 1.0 - initial release
// ============================================================================
package btn_counter_pkg;

   localparam int DEF_WIDTH                    = 4;
   localparam int DEF_DEBOUNCE_COUNT_THRESHOLD = 300;
   localparam bit DEF_WRAP                     = 1'b1;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_CLR  = 2'd1,
      OP_INC  = 2'd2,
      OP_DEC  = 2'd3
   } count_op_e;

   // Clear dominates; opposing up/down presses in the same cycle cancel out.
   function automatic count_op_e decode_op(input logic clr, input logic up, input logic dn);
      count_op_e op;
      op = OP_NONE;
      if (clr) begin
         op = OP_CLR;
      end else if (up && !dn) begin
         op = OP_INC;
      end else if (dn && !up) begin
         op = OP_DEC;
      end
      return op;
   endfunction

endpackage : btn_counter_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronises one raw button, accepts a level change only after
//               it has been stable for DEBOUNCE_COUNT_THRESHOLD cycles, and
//               emits a one-cycle pulse on each accepted press (rising edge).
//               Ports:
//                 sysclk - clock, all state on rising edge
//                 reset  - synchronous active-high reset
//                 btn    - raw asynchronous button input
//                 press  - one-cycle pulse per debounced press
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
   import btn_counter_pkg::*;
#(
   parameter int DEBOUNCE_COUNT_THRESHOLD = DEF_DEBOUNCE_COUNT_THRESHOLD
) (
   input  logic sysclk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int C_CNT_W = (DEBOUNCE_COUNT_THRESHOLD > 1) ?
                            $clog2(DEBOUNCE_COUNT_THRESHOLD) : 1;
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DEBOUNCE_COUNT_THRESHOLD - 1);
   localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);

   logic               sync1_q;
   logic               sync2_q;
   logic               db_q;
   logic               db_d;
   logic               db_prev_q;
   logic [C_CNT_W-1:0] stable_q;
   logic [C_CNT_W-1:0] stable_d;

   // The stable counter only runs while the synchronised level disagrees with
   // the accepted level; any agreement restarts the qualification window.
   always_comb begin
      db_d     = db_q;
      stable_d = '0;
      if (sync2_q != db_q) begin
         if (stable_q == C_LAST) begin
            db_d     = sync2_q;
            stable_d = '0;
         end else begin
            stable_d = stable_q + C_ONE;
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         stable_q  <= '0;
      end else begin
         sync1_q   <= btn;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         stable_q  <= stable_d;
      end
   end

   // Rising edge of the debounced level only; releases are silent.
   assign press = db_q & ~db_prev_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/btn_counter.sv
`default_nettype none
// ============================================================================
// Module      : btn_counter
// Description : Up/down/clear counter driven by three debounced push buttons,
//               with optional wrap or saturation and over/underflow pulses.
//               Ports:
//                 sysclk   - clock, all state on rising edge
//                 reset    - synchronous active-high reset
//                 btn_up   - raw button, press increments
//                 btn_down - raw button, press decrements
//                 btn_clr  - raw button, press clears
//                 led      - registered count [WIDTH-1:0]
//                 ovf      - one-cycle pulse on increment request at max
//                 udf      - one-cycle pulse on decrement request at zero
// Revision    : 1.0 - initial release
// ============================================================================
module btn_counter
   import btn_counter_pkg::*;
#(
   parameter int WIDTH                    = DEF_WIDTH,
   parameter int DEBOUNCE_COUNT_THRESHOLD = DEF_DEBOUNCE_COUNT_THRESHOLD,
   parameter bit WRAP                     = DEF_WRAP
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_clr,
   output logic [WIDTH-1:0] led,
   output logic             ovf,
   output logic             udf
);

   localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

   logic             w_up_press;
   logic             w_dn_press;
   logic             w_clr_press;
   count_op_e        w_op;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             udf_q;
   logic             udf_d;

   btn_debounce #(
      .DEBOUNCE_COUNT_THRESHOLD (DEBOUNCE_COUNT_THRESHOLD)
   ) u_db_up (
      .sysclk (sysclk),
      .reset  (reset),
      .btn    (btn_up),
      .press  (w_up_press)
   );

   btn_debounce #(
      .DEBOUNCE_COUNT_THRESHOLD (DEBOUNCE_COUNT_THRESHOLD)
   ) u_db_down (
      .sysclk (sysclk),
      .reset  (reset),
      .btn    (btn_down),
      .press  (w_dn_press)
   );

   btn_debounce #(
      .DEBOUNCE_COUNT_THRESHOLD (DEBOUNCE_COUNT_THRESHOLD)
   ) u_db_clr (
      .sysclk (sysclk),
      .reset  (reset),
      .btn    (btn_clr),
      .press  (w_clr_press)
   );

   always_comb begin
      w_op    = decode_op(w_clr_press, w_up_press, w_dn_press);
      count_d = count_q;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      case (w_op)
         OP_CLR: begin
            count_d = '0;
         end
         OP_INC: begin
            if (count_q == C_MAX) begin
               // Flag fires whether the count wraps or saturates.
               ovf_d   = 1'b1;
               count_d = WRAP ? '0 : C_MAX;
            end else begin
               count_d = count_q + C_ONE;
            end
         end
         OP_DEC: begin
            if (count_q == '0) begin
               udf_d   = 1'b1;
               count_d = WRAP ? C_MAX : '0;
            end else begin
               count_d = count_q - C_ONE;
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign led = count_q;
   assign ovf = ovf_q;
   assign udf = udf_q;

endmodule : btn_counter
`default_nettype wire
